// File: rtl/mac_array_stream.sv
// Streaming N-lane multiply-accumulate array: collects K operand beats per result,
// then presents the per-lane sums until the consumer takes them.

module mac_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  ovf
);
  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH:0]      sum;

  assign prod = a * b;
  // One extra bit catches the carry out of the accumulator.
  assign sum  = {1'b0, acc} + {{(ACC_WIDTH+1-2*DATA_WIDTH){1'b0}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      if (sum[ACC_WIDTH]) begin
        ovf <= 1'b1;
        acc <= SATURATE ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
      end else begin
        acc <= sum[ACC_WIDTH-1:0];
      end
    end
  end
endmodule

module mac_array_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 8,
  parameter int K          = 8,
  parameter int ACC_WIDTH  = 3*DATA_WIDTH,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clr,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [N-1:0][DATA_WIDTH-1:0]       a_in,
  input  logic [DATA_WIDTH-1:0]              b_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [N-1:0][ACC_WIDTH-1:0]        c_out,
  output logic [N-1:0]                       ovf,
  output logic [$clog2(K+1)-1:0]             beat_cnt
);
  localparam int CW = $clog2(K+1);

  typedef enum logic {ACC, HOLD} state_t;
  state_t state;

  logic accept, take, lane_clr;

  assign in_ready  = rst_n && (state == ACC) && !clr;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign take      = (state == HOLD) && out_ready;
  assign lane_clr  = clr || take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACC;
      beat_cnt <= '0;
    end else if (clr || take) begin
      state    <= ACC;
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + CW'(1);
      if (beat_cnt == CW'(K-1)) state <= HOLD;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .SATURATE  (SATURATE)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (lane_clr),
      .en   (accept),
      .a    (a_in[g]),
      .b    (b_in),
      .acc  (c_out[g]),
      .ovf  (ovf[g])
    );
  end
endmodule

// File: tb/tb_mac_array_stream.sv
// Bench for mac_array_stream: four configurations share one stimulus stream and are
// compared every cycle against an exact-sum reference model, plus directed corner cases.

module tb_mac_array_stream;
  logic clk, rst_n, clr, in_valid, out_ready;
  logic [7:0][7:0] a;
  logic [7:0]      b;

  logic rdy0, rdy1, rdy2, rdy3, vld0, vld1, vld2, vld3;
  logic [7:0][23:0] c0, c3;
  logic [7:0][15:0] c1, c2;
  logic [7:0] ovf0, ovf1, ovf2, ovf3;
  logic [2:0] cnt0, cnt1, cnt2;
  logic [0:0] cnt3;

  // 0: K=4 ACC24 wrap, 1: K=4 ACC16 sat, 2: K=4 ACC16 wrap, 3: K=1 ACC24 wrap
  mac_array_stream #(.DATA_WIDTH(8), .N(8), .K(4), .ACC_WIDTH(24), .SATURATE(1'b0)) d24 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy0), .a_in(a),
    .b_in(b), .out_valid(vld0), .out_ready(out_ready), .c_out(c0), .ovf(ovf0), .beat_cnt(cnt0));
  mac_array_stream #(.DATA_WIDTH(8), .N(8), .K(4), .ACC_WIDTH(16), .SATURATE(1'b1)) s16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy1), .a_in(a),
    .b_in(b), .out_valid(vld1), .out_ready(out_ready), .c_out(c1), .ovf(ovf1), .beat_cnt(cnt1));
  mac_array_stream #(.DATA_WIDTH(8), .N(8), .K(4), .ACC_WIDTH(16), .SATURATE(1'b0)) w16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy2), .a_in(a),
    .b_in(b), .out_valid(vld2), .out_ready(out_ready), .c_out(c2), .ovf(ovf2), .beat_cnt(cnt2));
  mac_array_stream #(.DATA_WIDTH(8), .N(8), .K(1), .ACC_WIDTH(24), .SATURATE(1'b0)) k1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy3), .a_in(a),
    .b_in(b), .out_valid(vld3), .out_ready(out_ready), .c_out(c3), .ovf(ovf3), .beat_cnt(cnt3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] c_all [4][8];
  logic [7:0]  ovf_all [4];
  logic        vld_all [4];
  logic        rdy_all [4];
  int          cnt_all [4];
  always_comb begin
    for (int l = 0; l < 8; l++) begin
      c_all[0][l] = c0[l];
      c_all[1][l] = 24'(c1[l]);
      c_all[2][l] = 24'(c2[l]);
      c_all[3][l] = c3[l];
    end
    ovf_all = '{ovf0, ovf1, ovf2, ovf3};
    vld_all = '{vld0, vld1, vld2, vld3};
    rdy_all = '{rdy0, rdy1, rdy2, rdy3};
    cnt_all = '{int'(cnt0), int'(cnt1), int'(cnt2), int'(cnt3)};
  end

  // Reference model: exact unbounded lane sums, result derived from them on demand.
  int     kk  [4] = '{4, 4, 4, 1};
  int     ww  [4] = '{24, 16, 16, 24};
  bit     sat [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  bit     m_hold [4];
  int     m_cnt  [4];
  longint m_sum  [4][8];

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear(input int d);
    m_hold[d] = 1'b0;
    m_cnt[d]  = 0;
    for (int l = 0; l < 8; l++) m_sum[d][l] = 0;
  endtask

  function automatic longint exp_c(input int d, input int l);
    longint mx = (longint'(1) << ww[d]) - 1;
    if (m_sum[d][l] > mx) return sat[d] ? mx : (m_sum[d][l] & mx);
    return m_sum[d][l];
  endfunction

  function automatic int exp_ovf(input int d);
    int v = 0;
    for (int l = 0; l < 8; l++)
      if (m_sum[d][l] > (longint'(1) << ww[d]) - 1) v |= (1 << l);
    return v;
  endfunction

  task automatic model_check();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("dut%0d out_valid", d), vld_all[d], m_hold[d]);
      chk($sformatf("dut%0d in_ready", d), rdy_all[d], !m_hold[d] && !clr);
      chk($sformatf("dut%0d beat_cnt", d), cnt_all[d], m_cnt[d]);
      chk($sformatf("dut%0d ovf", d), ovf_all[d], exp_ovf(d));
      for (int l = 0; l < 8; l++)
        chk($sformatf("dut%0d c_out[%0d]", d, l), c_all[d][l], exp_c(d, l));
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 4; d++) begin
      if (clr) model_clear(d);
      else if (m_hold[d] && out_ready) model_clear(d);
      else if (!m_hold[d] && in_valid) begin
        for (int l = 0; l < 8; l++) m_sum[d][l] += longint'(a[l]) * longint'(b);
        m_cnt[d]++;
        if (m_cnt[d] == kk[d]) m_hold[d] = 1'b1;
      end
    end
  endtask

  // Called one time unit after a rising edge with inputs already set.
  task automatic step();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_a(input int base, input int inc);
    for (int l = 0; l < 8; l++) a[l] = 8'(base + inc * l);
  endtask

  typedef struct {
    bit iv;
    bit ordy;
    int exp_vld;
    int exp_rdy;
    int exp_cnt;
    int exp_scale;
  } vec_t;
  vec_t tbl [20];

  int hs;

  initial begin
    tbl[0]  = '{1, 0, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 0, 1, 1, 2};
    tbl[2]  = '{1, 0, 0, 1, 2, 4};
    tbl[3]  = '{1, 0, 0, 1, 3, 6};
    tbl[4]  = '{0, 0, 1, 0, 4, 8};
    tbl[5]  = '{0, 1, 1, 0, 4, 8};
    tbl[6]  = '{1, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 1, 2};
    tbl[8]  = '{1, 0, 0, 1, 1, 2};
    tbl[9]  = '{0, 0, 0, 1, 2, 4};
    tbl[10] = '{1, 0, 0, 1, 2, 4};
    tbl[11] = '{0, 0, 0, 1, 3, 6};
    tbl[12] = '{1, 0, 0, 1, 3, 6};
    tbl[13] = '{1, 0, 1, 0, 4, 8};
    tbl[14] = '{1, 0, 1, 0, 4, 8};
    tbl[15] = '{0, 0, 1, 0, 4, 8};
    tbl[16] = '{1, 0, 1, 0, 4, 8};
    tbl[17] = '{0, 0, 1, 0, 4, 8};
    tbl[18] = '{0, 1, 1, 0, 4, 8};
    tbl[19] = '{0, 0, 0, 1, 0, 0};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_a(1, 1); b = 8'd2;
    for (int d = 0; d < 4; d++) model_clear(d);
    #3;
    chk("reset out_valid", vld0, 0);
    chk("reset in_ready", rdy0, 0);
    chk("reset c_out", c0, 0);
    chk("reset beat_cnt", cnt0, 0);
    #4 rst_n = 1'b1;
    #1 chk("in_ready after release", rdy0, 1);

    // Basic K=4 result, gaps and a long HOLD, checked against the table.
    for (int i = 0; i < 20; i++) begin
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d out_valid", i), vld0, tbl[i].exp_vld);
      chk($sformatf("tbl%0d in_ready", i), rdy0, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d beat_cnt", i), cnt0, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d ovf", i), ovf0, 0);
      for (int l = 0; l < 8; l++)
        chk($sformatf("tbl%0d c_out[%0d]", i, l), c0[l], tbl[i].exp_scale * (l + 1));
      step();
    end

    // Overflow: 4 x 255*255 in 16-bit accumulators.
    clr = 1'b1; in_valid = 1'b0; out_ready = 1'b0; step();
    clr = 1'b0; in_valid = 1'b1; set_a(255, 0); b = 8'd255;
    repeat (4) step();
    in_valid = 1'b0;
    #1;
    chk("sat c_out[0]", c1[0], 65535);
    chk("sat c_out[7]", c1[7], 65535);
    chk("sat ovf", ovf1, 8'hFF);
    chk("wrap c_out[0]", c2[0], 63492);
    chk("wrap c_out[7]", c2[7], 63492);
    chk("wrap ovf", ovf2, 8'hFF);
    out_ready = 1'b1; step();
    out_ready = 1'b0; step();
    chk("sat ovf after handshake", ovf1, 0);
    chk("wrap ovf after handshake", ovf2, 0);

    // clr discards partial sums, then clr in HOLD drops the result.
    in_valid = 1'b1; set_a(7, 0); b = 8'd9;
    repeat (2) step();
    clr = 1'b1; step();
    clr = 1'b0; set_a(1, 0); b = 8'd1;
    repeat (4) step();
    in_valid = 1'b0;
    #1;
    chk("clr out_valid", vld0, 1);
    chk("clr c_out[0]", c0[0], 4);
    chk("clr c_out[5]", c0[5], 4);
    clr = 1'b1; step();
    clr = 1'b0;
    chk("clr in HOLD out_valid", vld0, 0);
    chk("clr in HOLD c_out", c0, 0);

    // Asynchronous reset while holding a result.
    in_valid = 1'b1; set_a(1, 1); b = 8'd3;
    repeat (4) step();
    in_valid = 1'b0;
    #1 chk("pre-reset out_valid", vld0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", vld0, 0);
    chk("async rst c_out", c0, 0);
    chk("async rst ovf", ovf1, 0);
    chk("async rst beat_cnt", cnt0, 0);
    chk("async rst in_ready", rdy0, 0);
    for (int d = 0; d < 4; d++) model_clear(d);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    repeat (4) step();
    in_valid = 1'b0;
    #1;
    chk("post-reset out_valid", vld0, 1);
    chk("post-reset c_out[0]", c0[0], 12);
    chk("post-reset c_out[7]", c0[7], 96);

    // K=1: one beat per result, a result every two cycles.
    clr = 1'b1; step();
    clr = 1'b0; in_valid = 1'b1; set_a(3, 0); b = 8'd5;
    step();
    #1;
    chk("k1 out_valid", vld3, 1);
    chk("k1 c_out[0]", c3[0], 15);
    chk("k1 beat_cnt", cnt3, 1);
    out_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 6; i++) begin
      #1 if (vld3 && out_ready) hs++;
      step();
    end
    chk("k1 handshakes in 6 cycles", hs, 3);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      clr       = ($urandom_range(0, 31) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      for (int l = 0; l < 8; l++) a[l] = 8'($urandom);
      b = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mac_array_stream.md
# mac_array_stream

Streaming N-lane multiply-accumulate array with valid/ready handshakes, fixed K-beat dot-product length, selectable saturating or wrapping accumulation and per-lane overflow flags. It sits between the operand feeder (vector A, broadcast scalar B) and the result consumer. It replaces the free-running enable/clear MAC bank with a self-sequencing block that emits one result vector every K accepted beats and holds it until the consumer takes it.

## Interface
- DATA_WIDTH, 8, operand width (A lanes and B), unsigned
- N, 8, lane count
- K, 8, beats per result (K >= 1)
- ACC_WIDTH, 3*DATA_WIDTH, accumulator/result width (>= 2*DATA_WIDTH)
- SATURATE, 0, 1 = clamp at 2^ACC_WIDTH-1, 0 = wrap modulo 2^ACC_WIDTH
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous abort/clear, highest priority after reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- a_in  in  DATA_WIDTH x [0:N-1]  per-lane A operand
- b_in  in  DATA_WIDTH  scalar B, broadcast to all lanes
- out_valid  out  1  c_out holds a complete result
- out_ready  in  1  consumer takes result
- c_out  out  ACC_WIDTH x [0:N-1]  per-lane accumulator
- ovf  out  N  per-lane sticky overflow for current result
- beat_cnt  out  $clog2(K+1)  beats accepted toward current result

## Operation
- States: ACC (collecting beats), HOLD (result presented). Reset state ACC.
- in_ready = rst_n && state==ACC && !clr. Beat accepted when in_valid && in_ready.
- Accepted beat: acc[i] <= acc[i] + a_in[i]*b_in for every lane; beat_cnt++.
- Products are unsigned 2*DATA_WIDTH, zero-extended to ACC_WIDTH+1 for the add; carry out of ACC_WIDTH sets ovf[i] (sticky). SATURATE=1: acc[i] <= all-ones on carry and stays saturated. SATURATE=0: acc[i] keeps low ACC_WIDTH bits.
- Accepting the K-th beat (beat_cnt==K-1): state -> HOLD next edge, beat_cnt -> K.
- HOLD: out_valid=1, in_ready=0, c_out/ovf stable. On out_valid && out_ready: acc, ovf, beat_cnt cleared, state -> ACC.
- clr=1 (any state): acc, ovf, beat_cnt <= 0, state <= ACC; no beat accepted that cycle; a pending result is discarded without a handshake.
- c_out drives accumulators directly; in ACC it shows partial sums (not valid to consumer).
- out_valid must not drop without a handshake except by clr or reset.

## Timing
- Reset (rst_n low, asynchronous): c_out all 0, ovf 0, beat_cnt 0, out_valid 0, in_ready 0, state ACC. in_ready rises in the first cycle after rst_n deasserts.
- Latency: out_valid asserted the cycle after the K-th beat is accepted; c_out includes that beat.
- Minimum period per result: K+1 cycles (K beats + one HOLD cycle with out_ready high). First beat of next result accepted the cycle after the output handshake.
- in_valid gaps stall accumulation with no state change; out_ready low holds HOLD indefinitely.
- K=1: every accepted beat goes straight to HOLD.
- Reset mid-operation: partial sums and held results lost immediately.

## Test plan
- N=8, K=4, ACC_WIDTH=24: 4 back-to-back beats a[i]=i+1, b=2 -> out_valid one cycle after 4th beat, c_out[i]=8*(i+1), ovf=0, beat_cnt=4.
- Same, in_valid toggling 1/0 and out_ready low for 5 cycles in HOLD -> same result, in_ready=0 and c_out unchanged throughout HOLD; next beat accepted the cycle after the handshake.
- ACC_WIDTH=16, a=255, b=255, 4 beats: SATURATE=1 -> c_out=65535, ovf=all 1s; SATURATE=0 -> c_out=63492, ovf=all 1s; ovf clears after handshake.
- clr after 2 beats, then 4 beats a=1, b=1 -> c_out=4 (old beats discarded); clr pulsed in HOLD -> out_valid drops next cycle, no result consumed.
- rst_n low asynchronously in HOLD -> out_valid, c_out, ovf, beat_cnt 0 without a clock edge; first result after release correct.
- K=1: single beat a=3, b=5 -> c_out=15 next cycle; consecutive results every 2 cycles with out_ready held high.
